// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: datapath widths, header field
// helpers and the router FSM state encoding.
package router_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = BYTE_W - ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    WAIT_TILL_EMPTY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } router_state_e;

  // Header layout: {len[LEN_W-1:0], addr[ADDR_W-1:0]}
  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
    return hdr[BYTE_W-1:ADDR_W];
  endfunction

endpackage

// File: rtl/router_reg_if.sv
// Byte datapath bus between the router FSM/input port and router_reg.
interface router_reg_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic [BYTE_W-1:0] data_in;
  logic              fifo_full;
  logic              rst_int_reg;
  logic              detect_add;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              lfd_state;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic [BYTE_W-1:0] dout;

  // Source side: input port plus FSM strobes
  modport master (
    output pkt_valid, data_in, fifo_full, rst_int_reg,
           detect_add, ld_state, laf_state, full_state, lfd_state,
    input  parity_done, low_pkt_valid, err, dout
  );

  // Register stage side
  modport slave (
    input  pkt_valid, data_in, fifo_full, rst_int_reg,
           detect_add, ld_state, laf_state, full_state, lfd_state,
    output parity_done, low_pkt_valid, err, dout
  );

endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, FIFO write byte, one-byte
// hold while the FIFO is full, and running XOR parity check.
module router_reg
  import router_pkg::*;
(
  input logic          clock,
  input logic          resetn,
  router_reg_if.slave  bus
);

  logic [BYTE_W-1:0] header_reg;
  logic [BYTE_W-1:0] full_byte_reg;
  logic [BYTE_W-1:0] int_parity;
  logic [BYTE_W-1:0] pkt_parity;

  // Capture the header byte unless it addresses the non-existent port 3
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      header_reg <= '0;
    else if (bus.detect_add && bus.pkt_valid && hdr_addr(bus.data_in) != ADDR_INVALID)
      header_reg <= bus.data_in;
  end

  // FIFO write-data bus: header, live payload, or the byte held while full
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      bus.dout <= '0;
    else if (bus.lfd_state)
      bus.dout <= header_reg;
    else if (bus.ld_state && !bus.fifo_full)
      bus.dout <= bus.data_in;
    else if (bus.laf_state)
      bus.dout <= full_byte_reg;
  end

  // Hold the byte that arrived while the FIFO was full
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      full_byte_reg <= '0;
    else if (bus.ld_state && bus.fifo_full)
      full_byte_reg <= bus.data_in;
  end

  // Running parity over header and payload; the trailing parity byte is kept apart
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      int_parity <= '0;
      pkt_parity <= '0;
    end else begin
      if (bus.detect_add)
        int_parity <= '0;
      else if (bus.lfd_state)
        int_parity <= int_parity ^ header_reg;
      else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
        int_parity <= int_parity ^ bus.data_in;

      if (bus.detect_add)
        pkt_parity <= '0;
      else if (bus.ld_state && !bus.pkt_valid)
        pkt_parity <= bus.data_in;
    end
  end

  // End-of-packet status: pkt_valid drop, parity captured, parity error
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      bus.low_pkt_valid <= 1'b0;
      bus.parity_done   <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      if (bus.rst_int_reg)
        bus.low_pkt_valid <= 1'b0;
      else if (bus.ld_state && !bus.pkt_valid)
        bus.low_pkt_valid <= 1'b1;

      // When the parity byte lands on a full FIFO, completion is deferred
      // to the first LOAD_AFTER_FULL edge that sees low_pkt_valid.
      if (bus.detect_add)
        bus.parity_done <= 1'b0;
      else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
               (bus.laf_state && bus.low_pkt_valid && !bus.parity_done))
        bus.parity_done <= 1'b1;

      if (bus.detect_add)
        bus.err <= 1'b0;
      else if (bus.parity_done)
        bus.err <= (int_parity != pkt_parity);
    end
  end

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg with hand-computed expected values.
module tb_router_reg;
  import router_pkg::*;

  logic clock;
  logic resetn;
  int unsigned n_checks;
  int unsigned n_errors;

  router_reg_if bus ();

  router_reg dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Apply one cycle of strobes/data, then sample 1 ns after the edge
  task automatic cyc(input logic da, input logic lfd, input logic ld,
                     input logic full, input logic laf, input logic pv,
                     input logic ff, input logic rir, input logic [7:0] d);
    bus.detect_add  = da;
    bus.lfd_state   = lfd;
    bus.ld_state    = ld;
    bus.full_state  = full;
    bus.laf_state   = laf;
    bus.pkt_valid   = pv;
    bus.fifo_full   = ff;
    bus.rst_int_reg = rir;
    bus.data_in     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, bus.dout, 8'h00);
    check({tag, "_err"}, {7'd0, bus.err}, 8'h00);
    check({tag, "_pdone"}, {7'd0, bus.parity_done}, 8'h00);
    check({tag, "_lowpv"}, {7'd0, bus.low_pkt_valid}, 8'h00);
  endtask

  logic [7:0] par;
  logic [7:0] b;

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0;
    bus.full_state = 0; bus.laf_state = 0; bus.pkt_valid = 0;
    bus.fifo_full = 0; bus.rst_int_reg = 0; bus.data_in = '0;
    resetn = 1'b1;
    #3;
    check_all_zero("reset");
    #9;
    resetn = 1'b0;

    // Header path
    cyc(1,0,0,0,0, 1,0,0, 8'h4A);
    cyc(0,1,0,0,0, 0,0,0, 8'h00);
    check("hdr_dout", bus.dout, 8'h4A);
    cyc(0,0,1,0,0, 1,0,0, 8'h11);
    check("hdr_payload", bus.dout, 8'h11);
    cyc(1,0,0,0,0, 1,0,0, 8'h4B);
    cyc(0,1,0,0,0, 0,0,0, 8'h00);
    check("hdr_invalid_addr", bus.dout, 8'h4A);

    // Good packet: parity 4A^11^22 = 79
    cyc(1,0,0,0,0, 1,0,0, 8'h4A);
    check("good_pdone_clr", {7'd0, bus.parity_done}, 8'h00);
    cyc(0,1,0,0,0, 1,0,0, 8'h00);
    cyc(0,0,1,0,0, 1,0,0, 8'h11);
    check("good_d0", bus.dout, 8'h11);
    cyc(0,0,1,0,0, 1,0,0, 8'h22);
    check("good_d1", bus.dout, 8'h22);
    cyc(0,0,1,0,0, 0,0,0, 8'h79);
    check("good_pdone", {7'd0, bus.parity_done}, 8'h01);
    check("good_lowpv", {7'd0, bus.low_pkt_valid}, 8'h01);
    cyc(0,0,0,0,0, 0,0,0, 8'h00);
    check("good_err", {7'd0, bus.err}, 8'h00);
    cyc(0,0,0,0,0, 0,0,1, 8'h00);
    check("good_rst_int", {7'd0, bus.low_pkt_valid}, 8'h00);

    // Bad parity: 0x00 against computed 0x79
    cyc(1,0,0,0,0, 1,0,0, 8'h4A);
    cyc(0,1,0,0,0, 1,0,0, 8'h00);
    cyc(0,0,1,0,0, 1,0,0, 8'h11);
    cyc(0,0,1,0,0, 1,0,0, 8'h22);
    cyc(0,0,1,0,0, 0,0,0, 8'h00);
    check("bad_pdone", {7'd0, bus.parity_done}, 8'h01);
    check("bad_err_early", {7'd0, bus.err}, 8'h00);
    cyc(0,0,0,0,0, 0,0,0, 8'h00);
    check("bad_err", {7'd0, bus.err}, 8'h01);
    // detect_add wins over a simultaneous parity capture
    cyc(1,0,1,0,0, 0,0,0, 8'h00);
    check("bad_clr_err", {7'd0, bus.err}, 8'h00);
    check("bad_clr_pdone", {7'd0, bus.parity_done}, 8'h00);
    // rst_int_reg wins over a simultaneous low_pkt_valid set
    cyc(0,0,1,0,0, 0,0,1, 8'h00);
    check("rst_int_prio", {7'd0, bus.low_pkt_valid}, 8'h00);

    // FIFO full: int parity = 4A^11^55 = 0E
    cyc(1,0,0,0,0, 1,0,0, 8'h4A);
    cyc(0,1,0,0,0, 1,0,0, 8'h00);
    cyc(0,0,1,0,0, 1,0,0, 8'h11);
    check("full_d0", bus.dout, 8'h11);
    cyc(0,0,1,0,0, 1,1,0, 8'h55);
    check("full_hold_ld", bus.dout, 8'h11);
    cyc(0,0,0,1,0, 1,1,0, 8'h00);
    check("full_hold_full", bus.dout, 8'h11);
    cyc(0,0,0,0,1, 1,0,0, 8'h00);
    check("full_laf_dout", bus.dout, 8'h55);
    check("full_laf_pdone", {7'd0, bus.parity_done}, 8'h00);
    cyc(0,0,1,0,0, 0,1,0, 8'h0E);
    check("full_par_hold", bus.dout, 8'h55);
    check("full_par_pdone", {7'd0, bus.parity_done}, 8'h00);
    check("full_par_lowpv", {7'd0, bus.low_pkt_valid}, 8'h01);
    cyc(0,0,0,1,0, 0,1,0, 8'h00);
    cyc(0,0,0,0,1, 0,0,0, 8'h00);
    check("full_laf2_dout", bus.dout, 8'h0E);
    check("full_laf2_pdone", {7'd0, bus.parity_done}, 8'h01);
    cyc(0,0,0,0,0, 0,0,0, 8'h00);
    check("full_err", {7'd0, bus.err}, 8'h00);
    cyc(0,0,0,0,0, 0,0,1, 8'h00);

    // Long packet: 18 random payload bytes
    cyc(1,0,0,0,0, 1,0,0, 8'h4A);
    cyc(0,1,0,0,0, 1,0,0, 8'h00);
    par = 8'h4A;
    for (int unsigned i = 0; i < 18; i++) begin
      b = 8'($urandom_range(0, 255));
      cyc(0,0,1,0,0, 1,0,0, b);
      check("long_dout", bus.dout, b);
      par = par ^ b;
    end
    cyc(0,0,1,0,0, 0,0,0, par);
    check("long_pdone", {7'd0, bus.parity_done}, 8'h01);
    cyc(0,0,0,0,0, 0,0,0, 8'h00);
    check("long_err", {7'd0, bus.err}, 8'h00);
    check("long_lowpv", {7'd0, bus.low_pkt_valid}, 8'h01);
    cyc(0,0,0,0,0, 0,0,1, 8'h00);
    check("long_rst_int", {7'd0, bus.low_pkt_valid}, 8'h00);

    // Mid-packet asynchronous reset with err set
    cyc(1,0,0,0,0, 1,0,0, 8'h4A);
    cyc(0,1,0,0,0, 1,0,0, 8'h00);
    cyc(0,0,1,0,0, 1,0,0, 8'h11);
    cyc(0,0,1,0,0, 0,0,0, 8'h00);
    cyc(0,0,0,0,0, 0,0,0, 8'h00);
    check("pre_rst_err", {7'd0, bus.err}, 8'h01);
    #2;
    resetn = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clock);
    #1;
    resetn = 1'b0;
    // Header register was cleared too
    cyc(0,1,0,0,0, 0,0,0, 8'h00);
    check("rst_hdr_clr", bus.dout, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/router_reg.md
# router_reg

Byte-wide datapath register stage of the 1x3 packet router, between the input port and the destination FIFOs. Under control of the router FSM state strobes it latches the header, forwards header and payload bytes to the FIFO write bus, and holds one byte when the FIFO is full. It also accumulates running XOR parity, compares it with the trailing parity byte, and reports a parity error.

## Interface
Parameters: none; widths are fixed by the shared package.
- clock in 1 — sole clock; all state updates on the rising edge
- resetn in 1 — asynchronous, active-high reset (port name kept for codebase consistency)
- pkt_valid in 1 — source asserts during header and payload; deasserts on the parity byte
- data_in in 8 — input byte: header {len[5:0], addr[1:0]}, payload, or parity
- fifo_full in 1 — selected destination FIFO is full
- rst_int_reg in 1 — FSM strobe; clears low_pkt_valid
- detect_add in 1 — FSM in DECODE_ADDRESS
- ld_state in 1 — FSM in LOAD_DATA
- laf_state in 1 — FSM in LOAD_AFTER_FULL
- full_state in 1 — FSM in FIFO_FULL_STATE
- lfd_state in 1 — FSM in LOAD_FIRST_DATA
- parity_done out 1 — parity byte captured
- low_pkt_valid out 1 — pkt_valid has fallen during a load
- err out 1 — parity mismatch
- dout out 8 — FIFO write-data bus

## Operation
All registers reset asynchronously to 0: dout, err, parity_done, low_pkt_valid, header_reg, full_byte_reg, int_parity, pkt_parity. Otherwise each register updates on the rising edge of clock, with the highest-priority true condition winning:
- header_reg: loads data_in when detect_add & pkt_valid & data_in[1:0]!=2'b11; otherwise holds.
- dout, in priority order:
  - lfd_state: header_reg
  - ld_state & !fifo_full: data_in
  - laf_state: full_byte_reg
  - otherwise: hold
- full_byte_reg: loads data_in when ld_state & fifo_full; otherwise holds.
- int_parity:
  - detect_add: 0
  - lfd_state: int_parity ^ header_reg
  - ld_state & pkt_valid & !full_state: int_parity ^ data_in
  - otherwise: hold
- pkt_parity:
  - detect_add: 0
  - ld_state & !pkt_valid: data_in
  - otherwise: hold
- low_pkt_valid:
  - rst_int_reg: 0
  - ld_state & !pkt_valid: 1
  - otherwise: hold
- parity_done:
  - detect_add: 0
  - (ld_state & !fifo_full & !pkt_valid) or (laf_state & low_pkt_valid & !parity_done): 1
  - otherwise: hold
- err:
  - detect_add: 0
  - parity_done: (int_parity != pkt_parity)
  - otherwise: hold
- Invalid address 2'b11 leaves header_reg unchanged.
- The parity byte is never folded into int_parity.

## Timing
- Header latch to dout: 1 cycle.
  - Edge N (detect_add): header_reg loads.
  - Edge N+1 (lfd_state): dout = header and int_parity = header.
- Payload: dout follows data_in with 1-cycle latency while ld_state & !fifo_full.
- Parity byte with fifo_full=0, at the capturing edge E:
  - pkt_parity, parity_done=1 and low_pkt_valid=1 all update at E.
  - err is valid at E+1.
- Parity byte with fifo_full=1: pkt_parity and low_pkt_valid still load at E. parity_done sets on the first laf_state edge with low_pkt_valid=1.
- Simultaneous events: detect_add overrides every parity update. rst_int_reg overrides the set of low_pkt_valid.
- Reset asserted mid-packet clears everything immediately. The next packet needs detect_add.

## Structure
- Shared package router_pkg:
  - BYTE_W=8, ADDR_W=2, LEN_W=6
  - ADDR_INVALID=2'b11
  - FSM state encoding, shared with the router FSM
- Single flat module. No sub-module is needed; parity logic is about 30 lines inline.

## Test plan
All cases use header 0x4A (len=18, addr=2) unless noted.
- Reset: assert resetn mid-operation → all outputs 0 immediately, including with no clock edge.
- Header path: detect_add+pkt_valid with data_in=0x4A, then lfd_state → dout=0x4A one edge later.
  - Repeat with data_in=0x4B (addr 3): header_reg keeps its previous value.
- Good packet: header 0x4A, payload 0x11, 0x22, then pkt_valid=0 with data_in=0x79 → dout=0x11, then 0x22.
  - parity_done=1 and low_pkt_valid=1 on the parity edge; err=0 on the next edge.
- Bad parity: same packet with a parity byte of 0x00 → err=1 one edge after parity_done.
  - A subsequent detect_add clears err and parity_done.
- FIFO full: in ld_state with fifo_full=1 and data_in=0x55 → dout holds.
  - Then full_state, then laf_state → dout=0x55.
  - If pkt_valid was already 0, parity_done sets on that laf_state edge.
- Long packet: 18 random payload bytes with correct parity → err=0.
  - Then rst_int_reg=1 → low_pkt_valid=0.
